// File: rtl/pipe_stage_track.sv
// pipe_stage_track: PC register and ID/EXE/MEM/WB instruction, valid and write-enable tracking for a 5-stage RV32 core.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   imem_rdata            instruction fetched at PC (combinational from imem)
//   regFileWe_ID          decoder write enable for the instruction in ID
//   PCEn, stall           PC advance enable, load-use stall request
//   flush_IF              discard the instruction leaving IF
//   PC_SrcMuxSel          redirect fetch to pc_target
//   PC                    current fetch address
//   instrCode_IF..WB      per-stage instruction (IF is a pass-through)
//   regFileWe_EXE..WB     per-stage register-file write enable
//   valid_ID..WB          stage holds a real (non-bubble) instruction
//   perf_retired/stall/flush  event counters, present only with PIPE_PERF_CNT_EN defined
module pipe_stage_track #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_rdata,
    input  logic        regFileWe_ID,
    input  logic        PCEn,
    input  logic        stall,
    input  logic        flush_IF,
    input  logic        PC_SrcMuxSel,
    input  logic [31:0] pc_target,
    output logic [31:0] PC,
    output logic [31:0] instrCode_IF,
    output logic [31:0] instrCode_ID,
    output logic [31:0] instrCode_EXE,
    output logic [31:0] instrCode_MEM,
    output logic [31:0] instrCode_WB,
    output logic        regFileWe_EXE,
    output logic        regFileWe_MEM,
    output logic        regFileWe_WB,
    output logic        valid_ID,
    output logic        valid_EXE,
    output logic        valid_MEM,
    output logic        valid_WB
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_q, exe_q, mem_q, wb_q;
    logic        vid_q, vexe_q, vmem_q, vwb_q;
    logic        weexe_q, wemem_q, wewb_q;
    logic        bubble;

    // Redirect beats PC advance, so a stall coinciding with a redirect still jumps.
    always_comb begin
        pc_d   = PC_SrcMuxSel ? pc_target : (PCEn ? pc_q + 32'd4 : pc_q);
        bubble = flush_IF | stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            id_q    <= NOP_INSTR;
            exe_q   <= NOP_INSTR;
            mem_q   <= NOP_INSTR;
            wb_q    <= NOP_INSTR;
            vid_q   <= 1'b0;
            vexe_q  <= 1'b0;
            vmem_q  <= 1'b0;
            vwb_q   <= 1'b0;
            weexe_q <= 1'b0;
            wemem_q <= 1'b0;
            wewb_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            id_q    <= bubble ? NOP_INSTR : imem_rdata;
            vid_q   <= ~bubble;
            exe_q   <= id_q;
            mem_q   <= exe_q;
            wb_q    <= mem_q;
            vexe_q  <= vid_q;
            vmem_q  <= vexe_q;
            vwb_q   <= vmem_q;
            // Gating with valid_ID keeps bubbles from ever writing the register file.
            weexe_q <= regFileWe_ID & vid_q;
            wemem_q <= weexe_q;
            wewb_q  <= wemem_q;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_retired_q, perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired_q <= 32'd0;
            perf_stall_q   <= 32'd0;
            perf_flush_q   <= 32'd0;
        end else begin
            perf_retired_q <= perf_retired_q + {31'd0, vwb_q};
            perf_stall_q   <= perf_stall_q + {31'd0, stall};
            perf_flush_q   <= perf_flush_q + {31'd0, flush_IF};
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
`endif

    assign PC            = pc_q;
    assign instrCode_IF  = imem_rdata;
    assign instrCode_ID  = id_q;
    assign instrCode_EXE = exe_q;
    assign instrCode_MEM = mem_q;
    assign instrCode_WB  = wb_q;
    assign valid_ID      = vid_q;
    assign valid_EXE     = vexe_q;
    assign valid_MEM     = vmem_q;
    assign valid_WB      = vwb_q;
    assign regFileWe_EXE = weexe_q;
    assign regFileWe_MEM = wemem_q;
    assign regFileWe_WB  = wewb_q;
endmodule

// File: tb/tb_pipe_stage_track.sv
// tb_pipe_stage_track: table-driven bench with an in-flight instruction scoreboard for pipe_stage_track.
module tb_pipe_stage_track;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hA000_0000;

    typedef struct {
        logic        pcen;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] target;
        logic        we;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic        v;
        logic        we;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_rdata;
    logic        regFileWe_ID, PCEn, stall, flush_IF, PC_SrcMuxSel;
    logic [31:0] pc_target;
    logic [31:0] PC, instrCode_IF, instrCode_ID, instrCode_EXE, instrCode_MEM, instrCode_WB;
    logic        regFileWe_EXE, regFileWe_MEM, regFileWe_WB;
    logic        valid_ID, valid_EXE, valid_MEM, valid_WB;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_retired, perf_stall, perf_flush;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_track dut (
        .clk(clk), .reset(reset), .imem_rdata(imem_rdata), .regFileWe_ID(regFileWe_ID),
        .PCEn(PCEn), .stall(stall), .flush_IF(flush_IF), .PC_SrcMuxSel(PC_SrcMuxSel),
        .pc_target(pc_target), .PC(PC), .instrCode_IF(instrCode_IF),
        .instrCode_ID(instrCode_ID), .instrCode_EXE(instrCode_EXE),
        .instrCode_MEM(instrCode_MEM), .instrCode_WB(instrCode_WB),
        .regFileWe_EXE(regFileWe_EXE), .regFileWe_MEM(regFileWe_MEM), .regFileWe_WB(regFileWe_WB),
        .valid_ID(valid_ID), .valid_EXE(valid_EXE), .valid_MEM(valid_MEM), .valid_WB(valid_WB)
`ifdef PIPE_PERF_CNT_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: each address returns a unique, non-NOP word.
    assign imem_rdata = TAG ^ PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " PC"}, PC, 32'h0);
        chk({tag, " ID"}, instrCode_ID, NOP);
        chk({tag, " EXE"}, instrCode_EXE, NOP);
        chk({tag, " MEM"}, instrCode_MEM, NOP);
        chk({tag, " WB"}, instrCode_WB, NOP);
        chk({tag, " valids"}, {28'd0, valid_ID, valid_EXE, valid_MEM, valid_WB}, 32'h0);
        chk({tag, " wes"}, {29'd0, regFileWe_EXE, regFileWe_MEM, regFileWe_WB}, 32'h0);
    endtask

    vec_t vt[18];
    ent_t q[$];
    ent_t e, wb;
    logic [31:0] cur_pc;

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h44};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h48};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h48};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4C};
        vt[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC};
        vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4};
        vt[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8};
        vt[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC};

        reset = 1'b1;
        regFileWe_ID = 1'b1; PCEn = 1'b1; stall = 1'b0; flush_IF = 1'b1;
        PC_SrcMuxSel = 1'b1; pc_target = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");

        for (int i = 0; i < 3; i++) q.push_back('{NOP, 1'b0, 1'b0});
        cur_pc = 32'h0;
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            reset        = 1'b0;
            PCEn         = vt[r].pcen;
            stall        = vt[r].stall;
            flush_IF     = vt[r].flush;
            PC_SrcMuxSel = vt[r].redir;
            pc_target    = vt[r].target;
            regFileWe_ID = vt[r].we;
            #1;
            chk($sformatf("r%0d IF", r), instrCode_IF, TAG ^ cur_pc);
            // The decoder's enable belongs to whatever entered ID last edge.
            q[q.size()-1].we = vt[r].we & q[q.size()-1].v;
            e = (vt[r].stall | vt[r].flush) ? '{NOP, 1'b0, 1'b0} : '{TAG ^ cur_pc, 1'b1, 1'b0};
            q.push_back(e);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d PC", r), PC, vt[r].exp_pc);
            chk($sformatf("r%0d ID", r), instrCode_ID, q[3].ins);
            chk($sformatf("r%0d vID", r), {31'd0, valid_ID}, {31'd0, q[3].v});
            chk($sformatf("r%0d EXE", r), instrCode_EXE, q[2].ins);
            chk($sformatf("r%0d vwEXE", r), {30'd0, valid_EXE, regFileWe_EXE}, {30'd0, q[2].v, q[2].we});
            chk($sformatf("r%0d MEM", r), instrCode_MEM, q[1].ins);
            chk($sformatf("r%0d vwMEM", r), {30'd0, valid_MEM, regFileWe_MEM}, {30'd0, q[1].v, q[1].we});
            wb = q.pop_front();
            chk($sformatf("r%0d WB", r), instrCode_WB, wb.ins);
            chk($sformatf("r%0d vwWB", r), {30'd0, valid_WB, regFileWe_WB}, {30'd0, wb.v, wb.we});
            cur_pc = vt[r].exp_pc;
        end

`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall", perf_stall, 32'd3);
        chk("perf_flush", perf_flush, 32'd2);
        @(negedge clk);
        force dut.perf_retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_retired_q;
        @(posedge clk);
        #1;
        chk("perf_retired wrap", perf_retired, 32'h0);
`endif

        @(negedge clk);
        reset = 1'b1; PCEn = 1'b1; stall = 1'b0; flush_IF = 1'b0; PC_SrcMuxSel = 1'b0; regFileWe_ID = 1'b1;
        @(posedge clk);
        #1;
        chk_cleared("midreset");

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post PC", PC, 32'h4);
        chk("post ID", instrCode_ID, TAG);
        chk("post vID", {31'd0, valid_ID}, 32'd1);
        chk("post vEXE", {31'd0, valid_EXE}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_track.md
# pipe_stage_track

Pipeline stage tracker for the 5-stage RV32 core: owns the PC register and the ID/EXE/MEM/WB instruction and write-enable registers. It produces the per-stage instruction codes and register-file write enables that the hazard unit consumes. It also applies the hazard unit's returned PC enable, stall and IF flush, inserting bubbles and redirecting fetch. It sits between instruction memory/decoder and the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- imem_rdata  in  32  instruction fetched at PC (combinational from instruction memory)
- regFileWe_ID  in  1  decoder write-enable for instruction currently in ID
- PCEn  in  1  PC advance enable (low during load-use stall)
- stall  in  1  load-use stall request
- flush_IF  in  1  discard instruction leaving IF
- PC_SrcMuxSel  in  1  redirect fetch to pc_target
- pc_target  in  32  redirect target address
- PC  out  32  current fetch address
- instrCode_IF  out  32  equals imem_rdata (pass-through)
- instrCode_ID / instrCode_EXE / instrCode_MEM / instrCode_WB  out  32 each  per-stage instruction
- regFileWe_EXE / regFileWe_MEM / regFileWe_WB  out  1 each  per-stage write enable
- valid_ID / valid_EXE / valid_MEM / valid_WB  out  1 each  stage holds a real (non-bubble) instruction

## Operation
- PC register, next-value priority: PC_SrcMuxSel -> pc_target; else PCEn -> PC+4 (32-bit, wraps at 2^32); else hold.
- ID register, priority: flush_IF or stall -> NOP_INSTR, valid_ID=0; else imem_rdata, valid_ID=1.
- On stall the instruction in ID still advances to EXE; the dependent instruction stays in IF because PC holds. IF re-presents it next cycle.
- EXE<=ID, MEM<=EXE, WB<=MEM unconditionally every cycle (instruction, valid).
- regFileWe_EXE <= regFileWe_ID & valid_ID; regFileWe_MEM <= regFileWe_EXE; regFileWe_WB <= regFileWe_MEM.
- Bubbles never carry a write enable.
- stall with PCEn=1 is an illegal combination. Behaviour follows the rules above with no special handling.
- No state machine beyond the registers. All outputs except instrCode_IF are registered.

## Timing
- Reset (synchronous, sampled on clk rising edge): PC=RESET_PC; all instrCode_ID..WB=NOP_INSTR; all valid_*=0; all regFileWe_*=0. Reset overrides every other input.
- Reset asserted mid-operation clears all in-flight instructions at that edge. The first fetch after deassertion is at RESET_PC.
- Latency: instruction fetched at edge N appears in ID after edge N+1, EXE after N+2, MEM after N+3, WB after N+4.
- Stall: one bubble per stall cycle in ID. PC is held for the same cycles.
- Redirect + flush on same edge: ID gets bubble, PC=pc_target, next cycle instrCode_IF is the target instruction.
- Simultaneous stall and PC_SrcMuxSel: redirect wins for PC; ID gets bubble.
- Simultaneous flush_IF and stall: single bubble, same as either alone.

## Configuration
- PIPE_PERF_CNT_EN defined: adds outputs perf_retired, perf_stall and perf_flush (32 bits each).
  - Counters reset to 0.
  - perf_retired increments each cycle valid_WB=1; perf_stall each cycle stall=1; perf_flush each cycle flush_IF=1.
  - All counters wrap modulo 2^32.
- Undefined: counters and ports absent, no other behavioural change.

## Test plan
- Reset -> PC=0, all stage instrCodes 32'h00000013, all valid/We 0. Release reset, imem returns I0..I4 at PC 0,4,...,16 -> I0 reaches WB after 4 edges with valid_WB=1.
- Load in ID with regFileWe_ID=1, stall=1, PCEn=0 for one cycle -> PC held (e.g. 0x8), ID=NOP, EXE=load with regFileWe_EXE=1. Next cycle the dependent instruction enters ID.
- PC_SrcMuxSel=1, flush_IF=1, pc_target=0x100 at PC=0x0C -> next PC=0x100, instrCode_ID=NOP, valid_ID=0, following fetch at 0x104.
- stall=1 and PC_SrcMuxSel=1 together, pc_target=0x40 -> PC=0x40, single bubble in ID, no duplicate instruction.
- Reset asserted with 4 valid instructions in flight -> all stages NOP/invalid next edge, PC=RESET_PC.
- With PIPE_PERF_CNT_EN: preload perf_retired near 0xFFFFFFFF via 2^32-1 retirements in simulation force → one more retirement gives 0. 3 stall cycles → perf_stall=3.
